uart_rx_word: RTL and testbench

Serial UART receiver and the receive-side counterpart of the uart_tx path. It samples an asynchronous 8N1 line, assembles bytes LSB-first, and packs four consecutive bytes into a 32-bit word. Each complete word is written to a downstream FIFO through a wr_en/full handshake. It sits between the board RX pin and the receive FIFO feeding the eth datapath.

---
 rtl/uart_rx_word.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_word.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver: samples the RX line mid-bit, assembles bytes LSB-first and
// packs WORD_BYTES consecutive bytes (first byte in the MSBs) into FIFO words.
module uart_rx_word #(
  parameter int CLKS_PER_BIT = 217,
  parameter int WORD_BYTES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in,
  input  logic                    full,
  output logic [8*WORD_BYTES-1:0] data_out,
  output logic                    wr_en,
  output logic [7:0]              byte_out,
  output logic                    pulse,
  output logic                    frame_err,
  output logic                    overflow,
  output logic                    busy
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_BYTES + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [1:0]    sync_q;
  logic          rx_s;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [W-1:0]  word_q, word_d, word_next;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;

  logic [W-1:0]  data_d;
  logic [7:0]    byte_d;
  logic          pulse_d, wr_en_d, frame_err_d, overflow_d;

  // Two-flop synchronizer; reset loads the idle (high) line level so no false start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], in};
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      data_out   <= '0;
      byte_out   <= '0;
      pulse      <= 1'b0;
      wr_en      <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      data_out   <= data_d;
      byte_out   <= byte_d;
      pulse      <= pulse_d;
      wr_en      <= wr_en_d;
      frame_err  <= frame_err_d;
      overflow   <= overflow_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    data_d      = data_out;
    byte_d      = byte_out;
    pulse_d     = 1'b0;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    word_next   = (word_q << 8) | W'(shift_q);

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          // A start bit that is high again at its midpoint was only a glitch.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d   = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          // Leave at mid stop bit so the next start edge half a bit later is caught.
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (rx_s) begin
            byte_d  = shift_q;
            pulse_d = 1'b1;
            word_d  = word_next;
            if (byte_cnt_q == BYTE_LAST) begin
              byte_cnt_d = '0;
              if (full) begin
                overflow_d = 1'b1;
              end else begin
                data_d  = word_next;
                wr_en_d = 1'b1;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + BW'(1);
            end
          end else begin
            frame_err_d = 1'b1;
            word_d      = '0;
            byte_cnt_d  = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: three instances (8, 4 and 217 clocks per bit)
// driven by a time-based serial sender so baud mismatch can be emulated.
module tb_uart_rx_word;

  localparam int HALF_PERIOD = 500;
  localparam int PERIOD      = 2 * HALF_PERIOD;

  logic        clk = 1'b0;
  logic        rst;
  logic        full;
  logic        rx_l     [3];
  logic [31:0] data_o   [3];
  logic        wr_o     [3];
  logic [7:0]  byte_o   [3];
  logic        pulse_o  [3];
  logic        fe_o     [3];
  logic        ov_o     [3];
  logic        busy_o   [3];

  logic [7:0]  bytes_q  [3][$];
  logic [31:0] words_q  [3][$];
  int          fe_cnt   [3];
  int          ov_cnt   [3];
  int          bad_cnt  [3];
  logic [3:0]  prev_strb[3];
  logic [7:0]  exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #HALF_PERIOD clk = ~clk;

  uart_rx_word #(.CLKS_PER_BIT(8), .WORD_BYTES(4)) u_dut8 (
    .clk(clk), .rst(rst), .in(rx_l[0]), .full(full),
    .data_out(data_o[0]), .wr_en(wr_o[0]), .byte_out(byte_o[0]), .pulse(pulse_o[0]),
    .frame_err(fe_o[0]), .overflow(ov_o[0]), .busy(busy_o[0])
  );

  uart_rx_word #(.CLKS_PER_BIT(4), .WORD_BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in(rx_l[1]), .full(full),
    .data_out(data_o[1]), .wr_en(wr_o[1]), .byte_out(byte_o[1]), .pulse(pulse_o[1]),
    .frame_err(fe_o[1]), .overflow(ov_o[1]), .busy(busy_o[1])
  );

  uart_rx_word #(.CLKS_PER_BIT(217), .WORD_BYTES(4)) u_dut217 (
    .clk(clk), .rst(rst), .in(rx_l[2]), .full(full),
    .data_out(data_o[2]), .wr_en(wr_o[2]), .byte_out(byte_o[2]), .pulse(pulse_o[2]),
    .frame_err(fe_o[2]), .overflow(ov_o[2]), .busy(busy_o[2])
  );

  // Event recorder, sampled on the falling edge away from the DUT update edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pulse_o[i]) bytes_q[i].push_back(byte_o[i]);
      if (wr_o[i]) begin
        words_q[i].push_back(data_o[i]);
        if (!pulse_o[i] || full) bad_cnt[i]++;
      end
      if (fe_o[i]) fe_cnt[i]++;
      if (ov_o[i]) ov_cnt[i]++;
      if (({pulse_o[i], wr_o[i], fe_o[i], ov_o[i]} & prev_strb[i]) != 4'b0) bad_cnt[i]++;
      prev_strb[i] = {pulse_o[i], wr_o[i], fe_o[i], ov_o[i]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bit_time(input int which, input int pct);
    int clks;
    case (which)
      0:       clks = 8;
      1:       clks = 4;
      default: clks = 217;
    endcase
    return clks * PERIOD * pct / 100;
  endfunction

  task automatic set_line(input int which, input logic v);
    rx_l[which] = v;
  endtask

  task automatic send(input int which, input logic [7:0] b, input logic stop, input int pct);
    int bt;
    bt = bit_time(which, pct);
    set_line(which, 1'b0);
    #(bt);
    for (int i = 0; i < 8; i++) begin
      set_line(which, b[i]);
      #(bt);
    end
    set_line(which, stop);
    #(bt);
    set_line(which, 1'b1);
  endtask

  task automatic send_word(input int which, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(which, w[8*i +: 8], 1'b1, 100);
  endtask

  task automatic gap(input int which, input int bits);
    #(bit_time(which, 100) * bits);
  endtask

  task automatic clear(input int which);
    bytes_q[which].delete();
    words_q[which].delete();
    fe_cnt[which]  = 0;
    ov_cnt[which]  = 0;
  endtask

  task automatic check_bytes(input int which, input string tag);
    check({tag, "_count"}, 32'(bytes_q[which].size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i),
            (i < bytes_q[which].size()) ? 32'(bytes_q[which][i]) : 32'hxxxx_xxxx,
            32'(exp_q[i]));
  endtask

  task automatic check_word(input int which, input string tag, input logic [31:0] exp);
    check({tag, "_wr_count"}, 32'(words_q[which].size()), 32'd1);
    check({tag, "_data_out"}, (words_q[which].size() > 0) ? words_q[which][0] : 32'hxxxx_xxxx, exp);
  endtask

  initial begin
    #(64'd100_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bt;
    logic [7:0] partial;

    rst  = 1'b1;
    full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_l[i]      = 1'b1;
      bad_cnt[i]   = 0;
      prev_strb[i] = 4'b0;
      clear(i);
    end
    repeat (4) @(negedge clk);
    check("reset_data_out",  data_o[0],         32'h0);
    check("reset_wr_en",     32'(wr_o[0]),      32'h0);
    check("reset_byte_out",  32'(byte_o[0]),    32'h0);
    check("reset_pulse",     32'(pulse_o[0]),   32'h0);
    check("reset_frame_err", 32'(fe_o[0]),      32'h0);
    check("reset_overflow",  32'(ov_o[0]),      32'h0);
    check("reset_busy",      32'(busy_o[0]),    32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back word receive.
    clear(0);
    send_word(0, 32'h2233_4455);
    gap(0, 2);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    check_bytes(0, "word");
    check_word(0, "word", 32'h2233_4455);
    check("word_frame_err", 32'(fe_cnt[0]), 32'd0);
    check("word_overflow",  32'(ov_cnt[0]), 32'd0);

    // Two-cycle start glitch must be rejected.
    clear(0);
    @(negedge clk);
    rx_l[0] = 1'b0;
    repeat (2) @(negedge clk);
    rx_l[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_high", 32'(busy_o[0]), 32'd1);
    gap(0, 20);
    check("glitch_pulses",    32'(bytes_q[0].size()), 32'd0);
    check("glitch_frame_err", 32'(fe_cnt[0]), 32'd0);
    check("glitch_wr",        32'(words_q[0].size()), 32'd0);
    check("glitch_busy_low",  32'(busy_o[0]), 32'd0);
    send(0, 8'hA5, 1'b1, 100);
    gap(0, 2);
    exp_q = '{8'hA5};
    check_bytes(0, "post_glitch");

    // Framing error discards the partial word (A5, 11, 22).
    clear(0);
    send(0, 8'h11, 1'b1, 100);
    send(0, 8'h22, 1'b1, 100);
    send(0, 8'h33, 1'b0, 100);
    gap(0, 2);
    check("ferr_strobe", 32'(fe_cnt[0]), 32'd1);
    send_word(0, 32'h4455_6677);
    gap(0, 2);
    exp_q = '{8'h11, 8'h22, 8'h44, 8'h55, 8'h66, 8'h77};
    check_bytes(0, "ferr");
    check_word(0, "ferr", 32'h4455_6677);
    check("ferr_strobe_total", 32'(fe_cnt[0]), 32'd1);

    // Completed word dropped while the FIFO is full.
    clear(0);
    @(negedge clk);
    full = 1'b1;
    send_word(0, 32'hDEAD_BEEF);
    gap(0, 2);
    check("ovf_strobe",   32'(ov_cnt[0]), 32'd1);
    check("ovf_no_wr",    32'(words_q[0].size()), 32'd0);
    check("ovf_hold",     data_o[0], 32'h4455_6677);
    check("ovf_pulses",   32'(bytes_q[0].size()), 32'd4);
    @(negedge clk);
    full = 1'b0;
    send_word(0, 32'h0102_0304);
    gap(0, 2);
    check_word(0, "after_ovf", 32'h0102_0304);
    check("after_ovf_strobe", 32'(ov_cnt[0]), 32'd1);

    // Reset during bit 3 of the second byte.
    clear(0);
    send(0, 8'h12, 1'b1, 100);
    bt      = bit_time(0, 100);
    partial = 8'h34;
    set_line(0, 1'b0);
    #(bt);
    for (int i = 0; i < 3; i++) begin
      set_line(0, partial[i]);
      #(bt);
    end
    set_line(0, partial[3]);
    #(bt / 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_data_out",  data_o[0],       32'h0);
    check("mid_rst_wr_en",     32'(wr_o[0]),    32'h0);
    check("mid_rst_byte_out",  32'(byte_o[0]),  32'h0);
    check("mid_rst_pulse",     32'(pulse_o[0]), 32'h0);
    check("mid_rst_frame_err", 32'(fe_o[0]),    32'h0);
    check("mid_rst_overflow",  32'(ov_o[0]),    32'h0);
    check("mid_rst_busy",      32'(busy_o[0]),  32'h0);
    set_line(0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    gap(0, 2);
    clear(0);
    send_word(0, 32'hCAFE_BABE);
    gap(0, 2);
    exp_q = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
    check_bytes(0, "post_rst");
    check_word(0, "post_rst", 32'hCAFE_BABE);

    // Baud extremes with +-2% sender mismatch.
    for (int w = 1; w < 3; w++) begin
      clear(w);
      for (int k = 0; k < 2; k++) begin
        send(w, 8'h55, 1'b1, (k == 0) ? 98 : 102);
        gap(w, 2);
        send(w, 8'hAA, 1'b1, (k == 0) ? 98 : 102);
        gap(w, 2);
      end
      exp_q = '{8'h55, 8'hAA, 8'h55, 8'hAA};
      check_bytes(w, $sformatf("baud%0d", w));
      check_word(w, $sformatf("baud%0d", w), 32'h55AA_55AA);
      check($sformatf("baud%0d_frame_err", w), 32'(fe_cnt[w]), 32'd0);
      check($sformatf("baud%0d_busy", w), 32'(busy_o[w]), 32'd0);
    end

    for (int i = 0; i < 3; i++)
      check($sformatf("strobe_rules_dut%0d", i), 32'(bad_cnt[i]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
